// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the pc_call_stack slice.
//   - CMD_* : encoded command selected each cycle after priority resolution
//             (clr > ret > call > lp > br > cp).
//   - sp_width(depth) : stack-pointer width able to hold 0..depth.
//   - pc_inc(x, last_addr) : sequential successor with wrap to 0.
package pc_pkg;

  localparam logic [2:0] CMD_NONE = 3'd0;
  localparam logic [2:0] CMD_CP   = 3'd1;
  localparam logic [2:0] CMD_BR   = 3'd2;
  localparam logic [2:0] CMD_LP   = 3'd3;
  localparam logic [2:0] CMD_CALL = 3'd4;
  localparam logic [2:0] CMD_RET  = 3'd5;
  localparam logic [2:0] CMD_CLR  = 3'd6;

  function automatic int sp_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // The >= (not ==) makes a loaded address beyond the wrap point fall back
  // to 0 on the next increment instead of running on to 2^WIDTH-1.
  function automatic logic [31:0] pc_inc(input logic [31:0] x,
                                         input logic [31:0] last_addr);
    return (x >= last_addr) ? 32'd0 : x + 32'd1;
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// pc_return_stack: synchronous LIFO of DEPTH x WIDTH return addresses.
// Ports:
//   clk, rst_n      : clock, async active-low reset (pointer only)
//   clr             : synchronous pointer clear
//   push, pop, din  : push din / pop top (caller never asserts both)
//   top             : entry at sp-1 (zero while empty)
//   empty, full     : sp == 0 / sp == DEPTH, decoded from the pointer flop
module pc_return_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int SPW  = sp_width(DEPTH);
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SPW-1:0]   sp_q, sp_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [IDXW-1:0]  wr_idx, rd_idx;

  assign empty  = (sp_q == '0);
  assign full   = (sp_q == SPW'(DEPTH));
  assign wr_idx = IDXW'(sp_q);
  assign rd_idx = IDXW'(sp_q - SPW'(1));
  assign top    = empty ? '0 : mem_q[rd_idx];

  always_comb begin
    sp_d = sp_q;
    if (clr)       sp_d = '0;
    else if (push) sp_d = sp_q + SPW'(1);
    else if (pop)  sp_d = sp_q - SPW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp_q <= '0;
    else        sp_q <= sp_d;
  end

  // Contents are never reset; only entries below sp are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_idx] <= din;
  end

endmodule

// File: rtl/pc_call_stack.sv
// pc_call_stack: WIDTH-bit program counter with programmable wrap point,
// absolute load, signed relative branch and a bounded call/return stack.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   clr,ret,call,lp,br,cp : commands, level-sampled at each rising edge;
//                           only the highest-priority asserted one acts
//   ep                    : output-enable request, registered into pc_oe
//   err_clr               : clears sticky ovf_err / unf_err (set wins)
//   load_val, offset      : lp/call target, two's-complement branch offset
//   pc, bus_out, pc_oe    : current address, gated bus copy, registered enable
//   stack_empty/full      : stack pointer at 0 / at STACK_DEPTH
//   ovf_err, unf_err      : call-while-full / ret-while-empty sticky flags
// There is no valid/ready handshake: every command is accepted on the edge
// where it is sampled and its effect is visible right after that edge.
module pc_call_stack
  import pc_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int LAST_ADDR   = 9,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             cp,
  input  logic             lp,
  input  logic             br,
  input  logic             call,
  input  logic             ret,
  input  logic             ep,
  input  logic             err_clr,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] offset,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] bus_out,
  output logic             pc_oe,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             ovf_err,
  output logic             unf_err
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pc_oe_q, pc_oe_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [2:0]       cmd_sel;
  logic [WIDTH-1:0] pc_next_seq;
  logic             push, pop, ovf_set, unf_set, stk_clr;
  logic [WIDTH-1:0] stk_top;
  logic             stk_empty, stk_full;

  assign pc_next_seq = WIDTH'(pc_inc(32'(pc_q), 32'(LAST_ADDR)));

  always_comb begin
    cmd_sel = CMD_NONE;
    if (clr)       cmd_sel = CMD_CLR;
    else if (ret)  cmd_sel = CMD_RET;
    else if (call) cmd_sel = CMD_CALL;
    else if (lp)   cmd_sel = CMD_LP;
    else if (br)   cmd_sel = CMD_BR;
    else if (cp)   cmd_sel = CMD_CP;
  end

  always_comb begin
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (cmd_sel)
      CMD_CLR:  pc_d = '0;
      CMD_RET: begin
        if (stk_empty) unf_set = 1'b1;
        else begin
          pc_d = stk_top;
          pop  = 1'b1;
        end
      end
      CMD_CALL: begin
        if (stk_full) ovf_set = 1'b1;
        else begin
          pc_d = load_val;
          push = 1'b1;
        end
      end
      CMD_LP:   pc_d = load_val;
      CMD_BR:   pc_d = pc_q + offset;  // natural mod 2^WIDTH, no LAST_ADDR wrap
      CMD_CP:   pc_d = pc_next_seq;
      default:  ;
    endcase
  end

  assign stk_clr = (cmd_sel == CMD_CLR);

  always_comb begin
    ovf_d   = (ovf_q & ~err_clr) | ovf_set;
    unf_d   = (unf_q & ~err_clr) | unf_set;
    pc_oe_d = ep;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      pc_oe_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      pc_oe_q <= pc_oe_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // The return address pushed is inc(pc), the instruction after the call.
  pc_return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stk_clr),
    .push  (push),
    .pop   (pop),
    .din   (pc_next_seq),
    .top   (stk_top),
    .empty (stk_empty),
    .full  (stk_full)
  );

  assign pc          = pc_q;
  assign pc_oe       = pc_oe_q;
  assign bus_out     = pc_oe_q ? pc_q : '0;
  assign stack_empty = stk_empty;
  assign stack_full  = stk_full;
  assign ovf_err     = ovf_q;
  assign unf_err     = unf_q;

endmodule

// File: tb/tb_pc_call_stack.sv
module tb_pc_call_stack;

  localparam int W = 13;  // {pc[4], bus_out[4], pc_oe, empty, full, ovf, unf}

  // command vector bit order: {err_clr, clr, ret, call, lp, br, cp}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_CP   = 7'b0000001;
  localparam logic [6:0] C_BR   = 7'b0000010;
  localparam logic [6:0] C_LP   = 7'b0000100;
  localparam logic [6:0] C_CALL = 7'b0001000;
  localparam logic [6:0] C_RET  = 7'b0010000;
  localparam logic [6:0] C_CLR  = 7'b0100000;
  localparam logic [6:0] C_ECLR = 7'b1000000;

  // expected flag nibble: {empty, full, ovf, unf}
  localparam logic [3:0] F_E  = 4'b1000;
  localparam logic [3:0] F_0  = 4'b0000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, cp, lp, br, call, ret, ep, err_clr;
  logic [3:0] load_val, offset;
  logic [3:0] pc, bus_out;
  logic       pc_oe, stack_empty, stack_full, ovf_err, unf_err;

  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  event         async_chk;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pc_call_stack #(
    .WIDTH(4), .LAST_ADDR(9), .STACK_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .cp(cp), .lp(lp), .br(br),
    .call(call), .ret(ret), .ep(ep), .err_clr(err_clr),
    .load_val(load_val), .offset(offset), .pc(pc), .bus_out(bus_out),
    .pc_oe(pc_oe), .stack_empty(stack_empty), .stack_full(stack_full),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [6:0] c, input logic [3:0] lv,
                       input logic [3:0] off, input logic e);
    {err_clr, clr, ret, call, lp, br, cp} = c;
    load_val = lv;
    offset   = off;
    ep       = e;
  endtask

  // Called at a falling edge: drive, record the post-edge expectation, and
  // move on to the next falling edge.
  task automatic step(input logic [6:0] c, input logic [3:0] lv,
                      input logic [3:0] off, input logic e,
                      input logic [3:0] epc, input logic [3:0] fl);
    drive(c, lv, off, e);
    exp_q.push_back({epc, (e ? epc : 4'h0), e, fl});
    @(negedge clk);
  endtask

  // ---------------- scoreboard monitor ----------------
  always begin
    @(posedge clk or async_chk);
    #1;
    if (exp_q.size() != 0) begin
      logic [W-1:0] exp_v, act_v;
      exp_v = exp_q.pop_front();
      act_v = {pc, bus_out, pc_oe, stack_empty, stack_full, ovf_err, unf_err};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL vec%0d: got pc=%0d bus=%0d oe=%b e/f/o/u=%b required pc=%0d bus=%0d oe=%b e/f/o/u=%b",
                 checks, act_v[12:9], act_v[8:5], act_v[4], act_v[3:0],
                 exp_v[12:9], exp_v[8:5], exp_v[4], exp_v[3:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    drive(C_NONE, 4'd0, 4'd0, 1'b0);
    #2;
    exp_q.push_back({4'd0, 4'd0, 1'b0, F_E});
    -> async_chk;
    @(negedge clk);
    rst_n = 1'b1;

    // cp for 12 cycles: 1..9, 0, 1, 2 with bus idle
    for (int i = 0; i < 12; i++)
      step(C_CP, 4'd0, 4'd0, 1'b0, 4'((i + 1) % 10), F_E);

    // ep one cycle early, load 13, then increment wraps the out-of-range value
    step(C_NONE, 4'd0,  4'd0, 1'b1, 4'd2,  F_E);
    step(C_LP,   4'd13, 4'd0, 1'b1, 4'd13, F_E);
    step(C_CP,   4'd0,  4'd0, 1'b1, 4'd0,  F_E);

    // relative branches, including wrap below zero
    step(C_LP, 4'd5, 4'd0,  1'b0, 4'd5,  F_E);
    step(C_BR, 4'd0, 4'he,  1'b0, 4'd3,  F_E);
    step(C_LP, 4'd1, 4'd0,  1'b0, 4'd1,  F_E);
    step(C_BR, 4'd0, 4'hd,  1'b0, 4'd14, F_E);

    // call burst to full, overflow, returns, underflow
    step(C_LP,   4'd2, 4'd0, 1'b0, 4'd2, F_E);
    step(C_CALL, 4'd7, 4'd0, 1'b0, 4'd7, F_0);
    step(C_CALL, 4'd7, 4'd0, 1'b0, 4'd7, F_0);
    step(C_CALL, 4'd7, 4'd0, 1'b0, 4'd7, F_0);
    step(C_CALL, 4'd7, 4'd0, 1'b0, 4'd7, 4'b0100);
    step(C_CALL, 4'd3, 4'd0, 1'b0, 4'd7, 4'b0110);
    step(C_RET,  4'd0, 4'd0, 1'b0, 4'd8, 4'b0010);
    step(C_RET,  4'd0, 4'd0, 1'b0, 4'd8, 4'b0010);
    step(C_RET,  4'd0, 4'd0, 1'b0, 4'd8, 4'b0010);
    step(C_RET,  4'd0, 4'd0, 1'b0, 4'd3, 4'b1010);
    step(C_RET,  4'd0, 4'd0, 1'b0, 4'd3, 4'b1011);
    step(C_ECLR, 4'd0, 4'd0, 1'b0, 4'd3, F_E);

    // a set in the same cycle as err_clr wins
    step(C_RET | C_ECLR, 4'd0, 4'd0, 1'b0, 4'd3, 4'b1001);
    step(C_ECLR,         4'd0, 4'd0, 1'b0, 4'd3, F_E);

    // priority: ret beats call/lp/cp; clr beats everything, flags untouched
    step(C_CP | C_LP | C_CALL | C_RET,         4'd5, 4'd0, 1'b0, 4'd3, 4'b1001);
    step(C_CP | C_LP | C_CALL | C_RET | C_CLR, 4'd5, 4'd0, 1'b0, 4'd0, 4'b1001);
    step(C_ECLR, 4'd0, 4'd0, 1'b0, 4'd0, F_E);
    step(C_LP,   4'd4, 4'd0, 1'b0, 4'd4, F_E);
    step(C_CALL, 4'd9, 4'd0, 1'b0, 4'd9, F_0);
    step(C_CP | C_LP | C_CALL | C_RET, 4'd1, 4'd0, 1'b0, 4'd5, F_E);
    step(C_CALL, 4'd6, 4'd0, 1'b0, 4'd6, F_0);
    step(C_CLR,  4'd0, 4'd0, 1'b0, 4'd0, F_E);

    // async reset in the middle of a call burst
    step(C_RET,  4'd0, 4'd0, 1'b1, 4'd0, 4'b1001);
    step(C_CALL, 4'd3, 4'd0, 1'b1, 4'd3, 4'b0001);
    step(C_CALL, 4'd3, 4'd0, 1'b1, 4'd3, 4'b0001);
    drive(C_CALL, 4'd3, 4'd0, 1'b1);
    #2;
    rst_n = 1'b0;
    exp_q.push_back({4'd0, 4'd0, 1'b0, F_E});
    -> async_chk;
    #1;
    drive(C_CP, 4'd0, 4'd0, 1'b0);
    #1;
    rst_n = 1'b1;
    exp_q.push_back({4'd1, 4'd0, 1'b0, F_E});
    @(negedge clk);
    step(C_CP, 4'd0, 4'd0, 1'b0, 4'd2, F_E);
    step(C_CP, 4'd0, 4'd0, 1'b0, 4'd3, F_E);
    drive(C_NONE, 4'd0, 4'd0, 1'b0);

    // bounded drain of the scoreboard
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending entries, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_call_stack.md
# pc_call_stack

Parametrised successor to the 4-bit program counter of the 8-bit CPU. It holds a WIDTH-bit instruction address with a programmable wrap point, and supports increment, absolute load, signed relative branch and a bounded call/return stack. The block sits between the control sequencer, which issues one-hot commands, and the address bus, which it drives through a registered output enable.

## Interface
Parameters:
- WIDTH, 4: address width in bits (legal range ≥2).
- LAST_ADDR, 9: highest sequential address; increment past it wraps to 0. Must be < 2^WIDTH.
- STACK_DEPTH, 4: return-address entries (≥1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of pc and stack pointer.
- cp  in  1  increment command.
- lp  in  1  absolute load command, pc <= load_val.
- br  in  1  relative branch command, pc <= pc + offset.
- call  in  1  push return address, jump to load_val.
- ret  in  1  pop return address into pc.
- ep  in  1  output-enable request.
- err_clr  in  1  clears the sticky error flags.
- load_val  in  WIDTH  target for lp and call.
- offset  in  WIDTH  two's-complement branch offset.
- pc  out  WIDTH  current address (always visible).
- bus_out  out  WIDTH  pc when pc_oe = 1, else all zeros (no tristate).
- pc_oe  out  1  ep registered by one cycle.
- stack_empty  out  1  stack pointer = 0.
- stack_full  out  1  stack pointer = STACK_DEPTH.
- ovf_err  out  1  sticky flag: call attempted while the stack was full.
- unf_err  out  1  sticky flag: ret attempted while the stack was empty.

## Operation
- Reset (rst_n = 0, async): pc = 0, sp = 0, pc_oe = 0, ovf_err = 0, unf_err = 0, stack_empty = 1, stack_full = 0. Stack contents need not be cleared.
- Command priority per cycle, highest first: clr > ret > call > lp > br > cp. Only the highest asserted command acts; lower ones are ignored that cycle. No command asserted means pc holds.
- inc(x) = 0 if x ≥ LAST_ADDR, else x+1. The ≥ comparison covers a loaded out-of-range value.
- cp: pc <= inc(pc).
- lp: pc <= load_val. The value is not range-checked.
- br: pc <= (pc + offset) mod 2^WIDTH. No wrap-at-LAST_ADDR on branch.
- call, stack not full: stack[sp] <= inc(pc); sp <= sp+1; pc <= load_val.
- call, stack full: pc, sp and stack are unchanged; ovf_err <= 1.
- ret, stack not empty: pc <= stack[sp-1]; sp <= sp-1.
- ret, stack empty: pc and sp are unchanged; unf_err <= 1.
- clr: pc <= 0, sp <= 0. Error flags are not affected.
- err_clr: clears both error flags. A set event in the same cycle wins, so the flag remains 1.
- ep: pc_oe <= ep every cycle, independent of commands.

## Timing
- All commands take effect at the rising edge on which they are sampled. The new pc is visible immediately after that edge (1-cycle latency).
- bus_out is combinational from the registered pc and pc_oe. After ep rises at edge N, bus_out carries the post-edge-N pc.
- stack_empty, stack_full, ovf_err and unf_err are decoded from or held in registers; no combinational path from the inputs.
- Back-to-back call/ret every cycle is supported at full rate.
- Asserting rst_n mid-sequence aborts immediately. Release takes effect cleanly at the next edge, with the commands on that edge honoured.

## Structure
- Shared package pc_pkg holds:
  - the command-priority localparams;
  - a function for inc() parametrised by LAST_ADDR;
  - the stack-pointer width, $clog2(STACK_DEPTH+1).
- Sub-module pc_return_stack is a synchronous LIFO of STACK_DEPTH × WIDTH.
  - Inputs: push, pop, din.
  - Outputs: top, empty, full.
  - Asynchronous reset of sp only.
- The top level handles priority, pc arithmetic, flags and pc_oe.

## Test plan
All scenarios use the defaults unless noted.
- Reset then cp held high for 12 cycles -> pc sequence 1,2,…,9,0,1,2. bus_out = 0 while ep = 0.
- lp with load_val = 13, then cp -> pc = 13, then 0. With ep = 1 one cycle earlier, bus_out = 13 when pc_oe = 1.
- pc = 5, br with offset = 4'b1110 (−2) -> pc = 3. Then pc = 1, br with offset = −3 -> pc = 14.
- pc = 2, call with load_val = 7 four times (jumping 7→7) -> stack_full = 1. A fifth call sets ovf_err = 1, with pc and sp unchanged. Four rets return pc = 8,8,8,3. A fifth ret sets unf_err = 1.
- Simultaneous cp, lp, call and ret with the stack empty -> only ret acts: unf_err = 1, pc unchanged. The same inputs with clr also high -> pc = 0, unf_err unchanged.
- rst_n pulsed low mid-cycle during a call burst -> pc, sp, pc_oe and flags are 0 asynchronously, before the next edge. After release, cp counts from 0.
